// File: rtl/lcd_arbiter.sv
// Burst arbiter sharing one LCD executor between two command sources.
// Round-robin grant per burst, beat-by-beat start/ready sequencing, hang guard.
module lcd_arbiter #(
  parameter int TIMEOUT   = 50000,
  parameter int MAX_BEATS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] beat_valid,
  input  logic [1:0] beat_last,
  input  logic [3:0] beat_op0,
  input  logic [3:0] beat_op1,
  input  logic [7:0] beat_data0,
  input  logic [7:0] beat_data1,
  output logic [1:0] gnt,
  output logic [1:0] beat_ack,
  output logic [3:0] exe_op,
  output logic [7:0] exe_data,
  output logic       exe_start,
  input  logic       exe_rdy,
  output logic       busy,
  output logic       timeout_err,
  output logic       len_err
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          last_q, last_d;
  logic          by_cnt_q, by_cnt_d;
  logic [1:0]    gnt_d, ack_d;
  logic [3:0]    op_d;
  logic [7:0]    data_d;
  logic          start_d, busy_d, tmo_d, len_d;
  logic          rel, sel, at_cap, tmo_hit;
  logic          own_req, own_valid, own_last;
  logic [3:0]    own_op;
  logic [7:0]    own_data;
  logic [1:0]    own_oh;

  assign own_req   = req[owner_q];
  assign own_valid = beat_valid[owner_q];
  assign own_last  = beat_last[owner_q];
  assign own_op    = owner_q ? beat_op1 : beat_op0;
  assign own_data  = owner_q ? beat_data1 : beat_data0;
  assign own_oh    = owner_q ? 2'b10 : 2'b01;
  assign bcnt_inc  = bcnt_q + BW'(1);
  assign at_cap    = (bcnt_inc == BW'(MAX_BEATS));
  assign tmo_hit   = (tcnt_q == TW'(TIMEOUT - 1));
  // both requesting: whoever was not served last; else the lone requester
  assign sel = (req == 2'b11) ? ~last_owner_q : req[1];

  // next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    bcnt_d       = bcnt_q;
    tcnt_d       = tcnt_q;
    last_d       = last_q;
    by_cnt_d     = by_cnt_q;
    gnt_d        = gnt;
    ack_d        = 2'b00;
    op_d         = exe_op;
    data_d       = exe_data;
    start_d      = 1'b0;
    tmo_d        = timeout_err;
    len_d        = len_err;
    rel          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = sel;
          gnt_d   = sel ? 2'b10 : 2'b01;
          bcnt_d  = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (!own_req) begin
          rel = 1'b1;
        end else if (own_valid && exe_rdy) begin
          op_d     = own_op;
          data_d   = own_data;
          start_d  = 1'b1;
          ack_d    = own_oh;
          bcnt_d   = bcnt_inc;
          last_d   = own_last | at_cap;
          by_cnt_d = ~own_last & at_cap;
          tcnt_d   = '0;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tmo_hit) begin
          tmo_d = 1'b1;
          rel   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (!exe_rdy) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tmo_hit) begin
          tmo_d = 1'b1;
          rel   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (exe_rdy) begin
            if (last_q || !own_req) begin
              rel = 1'b1;
              if (last_q && by_cnt_q) len_d = 1'b1;
            end else begin
              state_d = ARM;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d      = IDLE;
      gnt_d        = 2'b00;
      last_owner_d = owner_q;
    end
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      bcnt_q       <= '0;
      tcnt_q       <= '0;
      last_q       <= 1'b0;
      by_cnt_q     <= 1'b0;
      gnt          <= 2'b00;
      beat_ack     <= 2'b00;
      exe_op       <= 4'h0;
      exe_data     <= 8'h00;
      exe_start    <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      bcnt_q       <= bcnt_d;
      tcnt_q       <= tcnt_d;
      last_q       <= last_d;
      by_cnt_q     <= by_cnt_d;
      gnt          <= gnt_d;
      beat_ack     <= ack_d;
      exe_op       <= op_d;
      exe_data     <= data_d;
      exe_start    <= start_d;
      busy         <= busy_d;
      timeout_err  <= tmo_d;
      len_err      <= len_d;
    end
  end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Bench for lcd_arbiter: behavioural requesters/executor, scoreboarded
// beats and grants, latency and sticky-error checks.
module tb_lcd_arbiter;

  localparam int TMO      = 20;
  localparam int MAXB     = 4;
  localparam int EXE_BUSY = 5;

  typedef struct packed {
    logic       o;
    logic [3:0] op;
    logic [7:0] d;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_r, req1_r, v0, v1, l0, l1;
  logic [3:0] op0, op1;
  logic [7:0] d0, d1;
  logic [1:0] req, beat_valid, beat_last;
  logic [1:0] gnt, beat_ack;
  logic [3:0] exe_op;
  logic [7:0] exe_data;
  logic       exe_start, exe_rdy, busy, timeout_err, len_err;

  assign req        = {req1_r, req0_r};
  assign beat_valid = {v1, v0};
  assign beat_last  = {l1, l0};

  lcd_arbiter #(.TIMEOUT(TMO), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req),
    .beat_valid(beat_valid), .beat_last(beat_last),
    .beat_op0(op0), .beat_op1(op1),
    .beat_data0(d0), .beat_data1(d1),
    .gnt(gnt), .beat_ack(beat_ack),
    .exe_op(exe_op), .exe_data(exe_data),
    .exe_start(exe_start), .exe_rdy(exe_rdy),
    .busy(busy), .timeout_err(timeout_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  beat_t exp_beats[$];
  bit    exp_gnts[$];
  bit    m_last = 1'b1;
  bit    hang = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] oh(input bit o);
    return o ? 2'b10 : 2'b01;
  endfunction

  function automatic int cap(input int n);
    return (n < MAXB) ? n : MAXB;
  endfunction

  function automatic bit pick(input bit r0, input bit r1);
    if (r0 && r1) return !m_last;
    return r1;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit o, input logic r);
    if (o) req1_r = r;
    else req0_r = r;
  endtask

  task automatic set_beat(input bit o, input logic v, input logic l,
                          input logic [3:0] op, input logic [7:0] d);
    if (o) begin
      v1 = v; l1 = l; op1 = op; d1 = d;
    end else begin
      v0 = v; l0 = l; op0 = op; d0 = d;
    end
  endtask

  task automatic expect_burst(input bit o, input int cnt,
                              input logic [3:0] op, input logic [7:0] db);
    beat_t b;
    exp_gnts.push_back(o);
    for (int i = 0; i < cnt; i++) begin
      b.o  = o;
      b.op = op;
      b.d  = db + 8'(i);
      exp_beats.push_back(b);
    end
    m_last = o;
  endtask

  task automatic settle();
    for (int c = 0; c < 200; c++) begin
      if (exe_rdy && !busy) break;
      @(posedge clk); #1;
    end
  endtask

  // requester: holds req, feeds beats one per ack, stops on release
  task automatic burst(input bit o, input int n, input bit use_last,
                       input int drop_after, input logic [3:0] op,
                       input logic [7:0] db, output int lat,
                       output int acks, output int rel_lat);
    int ack_cyc;
    bit got;
    acks = 0; lat = -1; rel_lat = -1; ack_cyc = cyc;
    set_req(o, 1'b1);
    set_beat(o, 1'b1, use_last && n == 1, op, db);
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (gnt[o]) begin lat = c; break; end
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL grant_wait%0d: got no grant expected grant", o);
      set_req(o, 1'b0);
      set_beat(o, 1'b0, 1'b0, 4'h0, 8'h00);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      set_beat(o, 1'b1, use_last && i == n - 1, op, db + 8'(i));
      got = 0;
      for (int c = 0; c < 300; c++) begin
        if (!gnt[o]) break;
        @(posedge clk); #1;
        if (beat_ack[o]) begin got = 1; break; end
      end
      if (!got) break;
      acks++;
      ack_cyc = cyc;
      set_beat(o, 1'b0, 1'b0, op, db + 8'(i));
      if (acks == drop_after) begin
        set_req(o, 1'b0);
        break;
      end
    end
    set_beat(o, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int c = 0; c < 300; c++) begin
      if (!gnt[o]) break;
      @(posedge clk); #1;
    end
    if (gnt[o]) begin
      n_chk++; n_fail++;
      $display("FAIL release_wait%0d: gnt %0b expected 0", o, gnt[o]);
    end else begin
      rel_lat = cyc - ack_cyc;
    end
    set_req(o, 1'b0);
  endtask

  // behavioural executor: drops ready after a start, busy EXE_BUSY cycles
  initial begin
    int left;
    left = 0;
    exe_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (exe_start) begin
        exe_rdy = 1'b0;
        left = EXE_BUSY;
      end else if (!exe_rdy && !hang) begin
        left--;
        if (left <= 0) exe_rdy = 1'b1;
      end
    end
  end

  // monitor: pops expected beats on exe_start and grants on gnt rise
  initial begin
    logic [1:0] pg;
    beat_t      b;
    bit         o;
    pg = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (exe_start === 1'b1) begin
        if (exp_beats.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL beat: got start op %0h data %0h expected none",
                   exe_op, exe_data);
        end else begin
          b = exp_beats.pop_front();
          check("beat", {16'h0, gnt, beat_ack, exe_op, exe_data},
                {16'h0, oh(b.o), oh(b.o), b.op, b.d});
        end
      end else if (beat_ack !== 2'b00 && !rst) begin
        n_chk++; n_fail++;
        $display("FAIL stray_ack: got %0b expected 00", beat_ack);
      end
      if (pg == 2'b00 && gnt != 2'b00 && gnt !== 2'bxx) begin
        if (exp_gnts.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL grant: got %0b expected none", gnt);
        end else begin
          o = exp_gnts.pop_front();
          check("grant", 32'(gnt), 32'(oh(o)));
        end
      end
      pg = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  la, aa, ra, lb, ab, rb;
    bit  f, s;
    logic [7:0] rd;
    rst = 1'b1;
    req0_r = 0; req1_r = 0;
    set_beat(0, 0, 0, 4'h0, 8'h00);
    set_beat(1, 0, 0, 4'h0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(exe_start), 0);
    check("rst_errs", {timeout_err, len_err}, 0);
    check("rst_op_data", {exe_op, exe_data}, 0);
    rst = 1'b0;
    m_last = 1'b1;
    @(posedge clk); #1;

    // single burst of three beats
    expect_burst(0, 3, 4'h1, 8'h41);
    burst(0, 3, 1, 0, 4'h1, 8'h41, la, aa, ra);
    check("single_lat", la, 1);
    check("single_acks", aa, 3);
    check("single_rel", ra, EXE_BUSY + 1);
    check("single_len_err", 32'(len_err), 0);

    // simultaneous requests, then alternation
    for (int k = 0; k < 2; k++) begin
      settle();
      f = pick(1, 1);
      s = !f;
      rd = 8'($urandom_range(0, 200));
      expect_burst(f, 1, f ? 4'h9 : 4'h2, rd);
      expect_burst(s, 1, s ? 4'h9 : 4'h2, rd + 8'h20);
      fork
        burst(0, 1, 1, 0, 4'h2, f ? rd + 8'h20 : rd, la, aa, ra);
        burst(1, 1, 1, 0, 4'h9, f ? rd : rd + 8'h20, lb, ab, rb);
      join
      check("sim_acks", aa + ab, 2);
    end

    // hung executor
    settle();
    check("pre_tmo", 32'(timeout_err), 0);
    hang = 1'b1;
    expect_burst(0, 1, 4'h3, 8'h30);
    burst(0, 2, 1, 0, 4'h3, 8'h30, la, aa, ra);
    check("tmo_rel", ra, TMO);
    check("tmo_acks", aa, 1);
    check("tmo_err", 32'(timeout_err), 1);
    check("tmo_gnt", 32'(gnt), 0);
    hang = 1'b0;
    expect_burst(1, 1, 4'h5, 8'h55);
    burst(1, 1, 1, 0, 4'h5, 8'h55, lb, ab, rb);
    check("post_tmo_acks", ab, 1);

    // over-long burst with beat_last never set
    settle();
    rd = 8'($urandom_range(0, 100));
    expect_burst(pick(1, 0), cap(6), 4'h6, rd);
    burst(0, 6, 0, 0, 4'h6, rd, la, aa, ra);
    check("long_acks", aa, cap(6));
    check("long_len_err", 32'(len_err), 1);
    check("long_gnt", 32'(gnt), 0);
    check("sticky_tmo", 32'(timeout_err), 1);

    // request dropped while the beat is in flight
    settle();
    expect_burst(0, 1, 4'hA, 8'hA0);
    burst(0, 3, 1, 1, 4'hA, 8'hA0, la, aa, ra);
    check("drop_acks", aa, 1);
    check("drop_rel", ra, EXE_BUSY + 1);

    // reset while waiting for the executor
    settle();
    expect_burst(0, 1, 4'h7, 8'h70);
    set_req(0, 1'b1);
    set_beat(0, 1'b1, 1'b0, 4'h7, 8'h70);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (beat_ack[0]) break;
    end
    set_beat(0, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    set_req(0, 1'b0);
    @(posedge clk); #1;
    check("mrst_gnt_ack", {gnt, beat_ack}, 0);
    check("mrst_start_busy", {exe_start, busy}, 0);
    check("mrst_op_data", {exe_op, exe_data}, 0);
    check("mrst_errs", {timeout_err, len_err}, 0);
    rst = 1'b0;
    m_last = 1'b1;
    settle();
    f = pick(1, 1);
    expect_burst(f, 1, f ? 4'hC : 4'hB, 8'hB0);
    expect_burst(!f, 1, !f ? 4'hC : 4'hB, 8'hC0);
    fork
      burst(0, 1, 1, 0, 4'hB, f ? 8'hC0 : 8'hB0, la, aa, ra);
      burst(1, 1, 1, 0, 4'hC, f ? 8'hB0 : 8'hC0, lb, ab, rb);
    join
    settle();
    repeat (3) @(posedge clk);
    #1;
    check("beats_left", exp_beats.size(), 0);
    check("grants_left", exp_gnts.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
